step_sequencer: RTL and testbench

Parametrised multi-channel step sequencer producing per-channel gate and note streams for the voice bank, replacing the hard-wired counter-bit gate decoding in the top level. Runs in the system clock domain, advances on a sample-rate enable, and reads a writable pattern memory of NUM_CH × NUM_STEPS entries. Outputs drive the voice `gate`/`note` inputs directly; an optional LFSR adds per-channel step probability.

---
 rtl/synth_pkg.sv | 38 +++
 rtl/seq_gate_timer.sv | 66 ++++++
 rtl/step_sequencer.sv | 171 +++++++++++++++++
 tb/tb_step_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// ============================================================================
// Module      : synth_pkg
// Description : Shared types and constants for the step sequencer: default
//               note width, pattern entry layout, sequencer state encoding
//               and the probability LFSR seed/taps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;

  // MIDI note number width used as the default for all sequencer instances
  localparam int NOTE_W_DEF = 7;

  // One pattern memory entry: gate_on flag above the note number
  typedef struct packed {
    logic                  gate_on;
    logic [NOTE_W_DEF-1:0] note;
  } pat_entry_t;

  // Sequencer top-level state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Galois LFSR for x^8+x^6+x^5+x^4+1, right-shifting form
  localparam logic [7:0] LFSR_SEED = 8'hE1;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Next LFSR value: shift right, fold taps in when a one falls out
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_gate_timer.sv
// ============================================================================
// Module      : seq_gate_timer
// Description : Per-channel gate generator. Opens the gate on a fire, counts
//               sample ticks while open and closes it after gate_len ticks
//               (gate_len = 0 holds it). A fire while the gate is already
//               open forces a one-tick low gap before reasserting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gate_timer #(
  parameter int GATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              fire,
  input  logic              clear,
  input  logic [GATE_W-1:0] gate_len,
  output logic              gate
);

  logic [GATE_W-1:0] r_cnt;
  logic              r_pend;
  logic [GATE_W-1:0] w_cnt_next;

  // Saturating increment so a held gate never wraps its counter
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + GATE_W'(1);

  // Gate state: clear beats fire, fire beats the per-tick bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate   <= 1'b0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else if (clear) begin
      gate   <= 1'b0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else if (fire) begin
      r_cnt <= '0;
      if (gate) begin
        // Retrigger: drop for one tick so the voice sees a fresh edge
        gate   <= 1'b0;
        r_pend <= 1'b1;
      end else begin
        gate   <= 1'b1;
        r_pend <= 1'b0;
      end
    end else if (sample_tick) begin
      if (r_pend) begin
        gate   <= 1'b1;
        r_pend <= 1'b0;
        r_cnt  <= '0;
      end else if (gate) begin
        r_cnt <= w_cnt_next;
        if ((gate_len != '0) && (w_cnt_next >= gate_len)) begin
          gate <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/step_sequencer.sv
// ============================================================================
// Module      : step_sequencer
// Description : Multi-channel step sequencer. Advances on sample_tick every
//               max(tempo_div,1) ticks, reads a writable NUM_CH x NUM_STEPS
//               pattern memory and drives per-channel gate/note outputs.
//               Optional build macro SEQ_RANDOM_EN adds an 8-bit LFSR that
//               gates each channel's fire against its prob byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_STEPS = 16,
  parameter int NOTE_W    = NOTE_W_DEF,
  parameter int TEMPO_W   = 16,
  parameter int GATE_W    = 8,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     run,
  input  logic [TEMPO_W-1:0]       tempo_div,
  input  logic [GATE_W-1:0]        gate_len,
  input  logic [NUM_CH*8-1:0]      prob,
  input  logic                     wr_en,
  input  logic [2:0]               wr_ch,
  input  logic [STEP_W-1:0]        wr_step,
  input  logic [NOTE_W:0]          wr_data,
  output logic [NUM_CH-1:0]        gate,
  output logic [NUM_CH*NOTE_W-1:0] note,
  output logic [STEP_W-1:0]        step_idx,
  output logic                     step_pulse
);

  seq_state_t                 r_state;
  logic                       r_started;
  logic [TEMPO_W-1:0]         r_tick_cnt;
  logic [STEP_W-1:0]          r_ptr;

  logic [TEMPO_W-1:0]         w_tdiv;
  logic [TEMPO_W-1:0]         w_cnt_inc;
  logic                       w_fire;
  logic                       w_clear;
  logic [STEP_W-1:0]          w_fire_ptr;
  logic [NUM_CH-1:0]          w_prob_ok;
  logic [NUM_CH-1:0]          w_ch_fire;
  logic [NUM_CH-1:0][NOTE_W:0] w_entry;

  // A tempo of zero behaves as one tick per step
  assign w_tdiv    = (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
  assign w_cnt_inc = r_tick_cnt + TEMPO_W'(1);

  // The very first tick after entering RUN fires step 0 without counting
  assign w_fire = (r_state == RUN) && run && sample_tick &&
                  (!r_started || (w_cnt_inc >= w_tdiv));
  assign w_fire_ptr = r_started ? r_ptr + STEP_W'(1) : r_ptr;
  assign w_clear    = (r_state == RUN) && !run;

`ifdef SEQ_RANDOM_EN
  logic [7:0] r_lfsr;

  // LFSR steps once per fire; the value before the step decides this fire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_fire) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_prob
    assign w_prob_ok[c] = (r_lfsr < prob[c*8 +: 8]);
  end
`else
  logic w_unused_prob;

  assign w_prob_ok     = '1;
  assign w_unused_prob = ^prob;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NOTE_W:0] r_mem [NUM_STEPS];

    // Pattern storage for this channel; the fire path reads the old word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < NUM_STEPS; s++) begin
          r_mem[s] <= '0;
        end
      end else if (wr_en && (wr_ch == 3'(c))) begin
        r_mem[wr_step] <= wr_data;
      end
    end

    assign w_entry[c]   = r_mem[w_fire_ptr];
    assign w_ch_fire[c] = w_fire & w_entry[c][NOTE_W] & w_prob_ok[c];

    seq_gate_timer #(
      .GATE_W (GATE_W)
    ) u_gate_timer (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .fire        (w_ch_fire[c]),
      .clear       (w_clear),
      .gate_len    (gate_len),
      .gate        (gate[c])
    );
  end

  // Sequencer FSM with tick counter, step pointer and registered fire outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_started  <= 1'b0;
      r_tick_cnt <= '0;
      r_ptr      <= '0;
      step_idx   <= '0;
      step_pulse <= 1'b0;
      note       <= '0;
    end else begin
      step_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_started  <= 1'b0;
          r_tick_cnt <= '0;
          r_ptr      <= '0;
          if (run) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!run) begin
            r_state    <= IDLE;
            r_started  <= 1'b0;
            r_tick_cnt <= '0;
            r_ptr      <= '0;
          end else if (sample_tick) begin
            if (w_fire) begin
              r_started  <= 1'b1;
              r_tick_cnt <= '0;
              r_ptr      <= w_fire_ptr;
            end else begin
              r_tick_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_fire) begin
        step_pulse <= 1'b1;
        step_idx   <= w_fire_ptr;
      end

      // Notes only change on a passing gate_on fire, otherwise they hold
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch_fire[c]) begin
          note[c*NOTE_W +: NOTE_W] <= w_entry[c][NOTE_W-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
// ============================================================================
// Module      : tb_step_sequencer
// Description : Self-checking bench for step_sequencer. A tick-level model
//               predicts gates/notes per sample tick; each predicted fire is
//               queued and popped when the DUT raises step_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_sequencer;
  import synth_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int NUM_STEPS = 16;
  localparam int NOTE_W    = 7;
  localparam int TEMPO_W   = 16;
  localparam int GATE_W    = 8;
  localparam int STEP_W    = 4;

  logic                     clk;
  logic                     rst;
  logic                     sample_tick;
  logic                     run;
  logic [TEMPO_W-1:0]       tempo_div;
  logic [GATE_W-1:0]        gate_len;
  logic [NUM_CH*8-1:0]      prob;
  logic                     wr_en;
  logic [2:0]               wr_ch;
  logic [STEP_W-1:0]        wr_step;
  logic [NOTE_W:0]          wr_data;
  logic [NUM_CH-1:0]        gate;
  logic [NUM_CH*NOTE_W-1:0] note;
  logic [STEP_W-1:0]        step_idx;
  logic                     step_pulse;

  typedef struct {
    int                       idx;
    logic [NUM_CH*NOTE_W-1:0] notes;
  } exp_t;

  exp_t sb[$];
  exp_t sb_pop;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Tick-level reference model state
  logic [NOTE_W:0]          m_pat [NUM_CH][NUM_STEPS];
  bit                       m_run, m_started;
  int                       m_cnt, m_ptr;
  bit   [NUM_CH-1:0]        m_gate, m_pend;
  int                       m_gcnt [NUM_CH];
  logic [NUM_CH*NOTE_W-1:0] m_note;
  logic [7:0]               m_lfsr;

  step_sequencer #(
    .NUM_CH    (NUM_CH),
    .NUM_STEPS (NUM_STEPS),
    .NOTE_W    (NOTE_W),
    .TEMPO_W   (TEMPO_W),
    .GATE_W    (GATE_W),
    .STEP_W    (STEP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .run         (run),
    .tempo_div   (tempo_div),
    .gate_len    (gate_len),
    .prob        (prob),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_step     (wr_step),
    .wr_data     (wr_data),
    .gate        (gate),
    .note        (note),
    .step_idx    (step_idx),
    .step_pulse  (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NOTE_W:0] ent(input bit g, input int n);
    pat_entry_t e;
    e.gate_on = g;
    e.note    = NOTE_W'(n);
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < NUM_STEPS; s++) m_pat[c][s] = '0;
      m_gcnt[c] = 0;
    end
    m_run = 0; m_started = 0; m_cnt = 0; m_ptr = 0;
    m_gate = '0; m_pend = '0; m_note = '0; m_lfsr = 8'hE1;
  endtask

  // Advance the model by one sample tick; queue the expected fire result
  task automatic model_tick(output bit fire);
    logic [NOTE_W:0] e;
    bit              pass;
    int              tdiv;
    fire = 0;
    if (!m_run) return;
    tdiv = (tempo_div == 0) ? 1 : int'(tempo_div);
    if (!m_started) begin
      m_started = 1; m_cnt = 0; m_ptr = 0; fire = 1;
    end else begin
      m_cnt++;
      if (m_cnt >= tdiv) begin
        m_cnt = 0; m_ptr = (m_ptr + 1) % NUM_STEPS; fire = 1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e    = m_pat[c][m_ptr];
      pass = 1'b1;
`ifdef SEQ_RANDOM_EN
      pass = (m_lfsr < prob[c*8 +: 8]);
`endif
      if (fire && e[NOTE_W] && pass) begin
        m_note[c*NOTE_W +: NOTE_W] = e[NOTE_W-1:0];
        m_gcnt[c] = 0;
        if (m_gate[c]) begin m_gate[c] = 0; m_pend[c] = 1; end
        else begin m_gate[c] = 1; m_pend[c] = 0; end
      end else if (m_pend[c]) begin
        m_gate[c] = 1; m_pend[c] = 0; m_gcnt[c] = 0;
      end else if (m_gate[c]) begin
        if (m_gcnt[c] < 255) m_gcnt[c]++;
        if (gate_len != 0 && m_gcnt[c] >= int'(gate_len)) m_gate[c] = 0;
      end
    end
    if (fire) begin
      m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[7:1]} ^ 8'hB8) : {1'b0, m_lfsr[7:1]};
      sb.push_back('{m_ptr, m_note});
    end
  endtask

  // One sample tick (optionally with a same-cycle write), then a gap cycle
  task automatic do_tick(input bit do_wr = 0, input int ch = 0, input int st = 0,
                         input logic [NOTE_W:0] d = '0);
    bit f;
    sample_tick = 1'b1;
    model_tick(f);
    if (do_wr) begin
      wr_en = 1'b1; wr_ch = 3'(ch); wr_step = STEP_W'(st); wr_data = d;
      if (ch < NUM_CH) m_pat[ch][st] = d;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    wr_en       = 1'b0;
    chk("step_pulse", step_pulse, f);
    chk("gate", gate, m_gate);
    chk("note", note, m_note);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic wr(input int ch, input int st, input logic [NOTE_W:0] d);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_step = STEP_W'(st); wr_data = d;
    if (ch < NUM_CH) m_pat[ch][st] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_run(input bit v);
    run = v;
    if (!v) begin
      m_run = 0; m_started = 0; m_cnt = 0; m_ptr = 0; m_gate = '0; m_pend = '0;
    end
    @(negedge clk);
    chk("gate_after_run_edge", gate, m_gate);
    if (v) m_run = 1;
  endtask

  // Scoreboard: every DUT step pulse must match the oldest predicted fire
  always @(negedge clk) begin
    if (rst && step_pulse) begin
      if (sb.size() == 0) begin
        chk("pulse_unexpected", step_pulse, 1'b0);
      end else begin
        sb_pop = sb.pop_front();
        chk("step_idx", step_idx, sb_pop.idx);
        chk("note_at_fire", note, sb_pop.notes);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sample_tick = 1'b0; run = 1'b0; wr_en = 1'b0;
    wr_ch = '0; wr_step = '0; wr_data = '0; tempo_div = 16'd4; gate_len = 8'd2;
`ifdef SEQ_RANDOM_EN
    prob = '1;
`else
    prob = '0;
`endif
    model_reset();
    #1;
    chk("rst_gate", gate, '0);
    chk("rst_note", note, '0);
    chk("rst_step_idx", step_idx, '0);
    chk("rst_step_pulse", step_pulse, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int s = 0; s < NUM_STEPS; s++) begin
      wr(0, s, ent(1, 60));
      wr(1, s, (s % 2 == 0) ? ent(1, 64) : ent(0, 0));
      wr(2, s, ent(1, 48));
      wr(3, s, ent(1, 36 + s));
    end
    wr(4, 3, ent(1, 99));

    // Basic stepping: tempo 4, gate 2, one full wrap back to step 0
    set_run(1'b1);
    ticks(1 + NUM_STEPS * 4);
    chk("wrap_idx", step_idx, 0);
`ifndef SEQ_RANDOM_EN
    chk("ch0_note60", note[NOTE_W-1:0], 60);
`endif
    set_run(1'b0);

    // Held gates with retrigger gaps
    gate_len = 8'd0;
    set_run(1'b1);
    ticks(13);
    set_run(1'b0);

    // Gate longer than a step period
    gate_len = 8'd10;
    set_run(1'b1);
    ticks(24);
    set_run(1'b0);

    // Fire every tick; write ch3 step 5 in the cycle it fires
    tempo_div = '0;
    gate_len  = 8'd1;
    set_run(1'b1);
    ticks(5);
    do_tick(1'b1, 3, 5, ent(1, 72));
`ifndef SEQ_RANDOM_EN
    chk("rbw_old_note", note[3*NOTE_W +: NOTE_W], 41);
`endif
    ticks(NUM_STEPS);
`ifndef SEQ_RANDOM_EN
    chk("rbw_new_note", note[3*NOTE_W +: NOTE_W], 72);
`endif
    set_run(1'b0);

    // Drop run at step 7, restart from step 0, then async reset mid-gate
    tempo_div = 16'd4;
    gate_len  = 8'd0;
    set_run(1'b1);
    ticks(1 + 7 * 4);
    chk("idx_before_stop", step_idx, 7);
    set_run(1'b0);
    set_run(1'b1);
    ticks(1);
    chk("idx_restart", step_idx, 0);
    ticks(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_gate", gate, '0);
    chk("arst_note", note, '0);
    chk("arst_step_idx", step_idx, '0);
    chk("arst_step_pulse", step_pulse, 1'b0);
    chk("sb_empty_at_reset", sb.size(), 0);
    run = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_run(1'b1);
    ticks(6);
    set_run(1'b0);

`ifdef SEQ_RANDOM_EN
    // Probability gating: ch0 never fires, ch1 fires unless LFSR is 8'hFF
    for (int s = 0; s < NUM_STEPS; s++) begin
      wr(0, s, ent(1, 60));
      wr(1, s, ent(1, 64));
    end
    prob      = {8'hFF, 8'hFF, 8'hFF, 8'h00};
    tempo_div = 16'd1;
    gate_len  = 8'd1;
    set_run(1'b1);
    ticks(40);
    set_run(1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
